// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN feature-map datapath.
package cnn_pkg;

  // Element width of the pooling input bus.
  localparam int DATA_W = 32;

  // Width of the framing-error counter.
  localparam int ERR_CNT_W = 8;

  typedef logic [DATA_W-1:0] elem_t;

  // Occupancy of one frame buffer bank.
  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_t;

  // Index width for a buffer of n entries; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fm_bank.sv
// One frame register bank: N elements written one at a time by index,
// read out as a single parallel frame.
module fm_bank #(
  parameter int N      = 16,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     we,
  input  logic [IDX_W-1:0]         widx,
  input  logic [DATA_W-1:0]        wdata,
  output logic [N-1:0][DATA_W-1:0] frame
);

  logic [N-1:0][DATA_W-1:0] mem_q;
  logic [N-1:0][DATA_W-1:0] mem_d;

  // Next contents: clear wins, otherwise write the addressed element.
  always_comb begin
    mem_d = mem_q;
    if (clr) begin
      mem_d = '0;
    end else if (we) begin
      mem_d[widx] = wdata;
    end
  end

  // Element storage.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign frame = mem_q;

endmodule

// File: rtl/feature_map_collector.sv
// Feature-map collector: gathers a serial row-major element stream into
// complete INPUT_SIZE x INPUT_SIZE frames using two ping-pong banks, and
// presents the oldest complete frame as a parallel bus to the pooling stage.
module feature_map_collector
  import cnn_pkg::*;
#(
  parameter int INPUT_SIZE = 4,
  parameter int DATA_W     = 32
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [DATA_W-1:0]                            in_data,
  input  logic                                         in_valid,
  input  logic                                         in_last,
  output logic                                         in_ready,
  output logic [INPUT_SIZE*INPUT_SIZE-1:0][DATA_W-1:0] frame_data,
  output logic                                         frame_valid,
  input  logic                                         frame_ready,
  output logic                                         frame_err,
  output logic [ERR_CNT_W-1:0]                         err_count
);

  localparam int N     = INPUT_SIZE * INPUT_SIZE;
  localparam int IDX_W = idx_width(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  // Saturating increment for the error counter.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == {ERR_CNT_W{1'b1}}) ? v : v + ERR_CNT_W'(1);
  endfunction

  bank_state_t              bank_st_q [2];
  bank_state_t              bank_st_d [2];
  logic                     wr_bank_q, wr_bank_d;
  logic                     rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]         wr_idx_q, wr_idx_d;
  logic                     frame_err_q, frame_err_d;
  logic [ERR_CNT_W-1:0]     err_cnt_q, err_cnt_d;

  logic                     accept;
  logic                     at_last;
  logic                     framing_err;
  logic                     frame_done;
  logic                     consume;
  logic [1:0]               bank_we;
  logic [N-1:0][DATA_W-1:0] bank_frame [2];

  // Handshakes, framing classification and the read-side output mux.
  always_comb begin
    in_ready    = rst_n && (bank_st_q[wr_bank_q] != BANK_FULL);
    accept      = in_valid && in_ready;
    at_last     = (wr_idx_q == LAST_IDX);
    // in_last must coincide exactly with the final slot; any other pairing
    // is a framing error and the element is dropped.
    framing_err = accept && (in_last != at_last);
    frame_done  = accept && in_last && at_last;
    frame_valid = (bank_st_q[rd_bank_q] == BANK_FULL);
    consume     = frame_valid && frame_ready;
    frame_data  = bank_frame[rd_bank_q];
    bank_we            = '0;
    bank_we[wr_bank_q] = accept && !framing_err;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fm_bank #(
      .N      (N),
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
    ) u_bank (
      .clk   (clk),
      .clr   (!rst_n),
      .we    (bank_we[b]),
      .widx  (wr_idx_q),
      .wdata (in_data),
      .frame (bank_frame[b])
    );
  end

  // Next-state for bank occupancy, pointers, write index and error tracking.
  always_comb begin
    bank_st_d   = bank_st_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_idx_d    = wr_idx_q;
    frame_err_d = framing_err;
    err_cnt_d   = framing_err ? sat_inc(err_cnt_q) : err_cnt_q;

    if (framing_err) begin
      // Restart the current bank from slot 0; its state is left as is.
      wr_idx_d = '0;
    end else if (accept) begin
      if (bank_st_q[wr_bank_q] == BANK_EMPTY) begin
        bank_st_d[wr_bank_q] = BANK_FILLING;
      end
      if (frame_done) begin
        bank_st_d[wr_bank_q] = BANK_FULL;
        wr_idx_d             = '0;
        wr_bank_d            = !wr_bank_q;
      end else begin
        wr_idx_d = wr_idx_q + IDX_W'(1);
      end
    end

    // The write bank is never FULL while accepting, and the read bank is
    // always FULL when consumed, so these never target the same bank.
    if (consume) begin
      bank_st_d[rd_bank_q] = BANK_EMPTY;
      rd_bank_d            = !rd_bank_q;
    end
  end

  // Control state registers; reset discards every partial and full frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_st_q[0] <= BANK_EMPTY;
      bank_st_q[1] <= BANK_EMPTY;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      wr_idx_q     <= '0;
      frame_err_q  <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      bank_st_q    <= bank_st_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      wr_idx_q     <= wr_idx_d;
      frame_err_q  <= frame_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign frame_err = frame_err_q;
  assign err_count = err_cnt_q;

endmodule

// File: doc/feature_map_collector.md
Name: feature_map_collector

Overview:
- Upstream feeder for the pooling stage. Accepts a serial stream of 32-bit feature-map elements (row-major, one per handshake) and assembles complete INPUT_SIZE x INPUT_SIZE frames.
- Presents each finished frame as a parallel packed array that plugs directly into the pooling layer's input_data bus.
- Ping-pong (two-bank) buffering: the next frame fills while the previous frame is held for the consumer.

Parameters:
- INPUT_SIZE, 4, feature-map side length; frame holds INPUT_SIZE*INPUT_SIZE elements (N).
- DATA_W, 32, element width; fixed at 32 to match the pooling bus.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_data  input  DATA_W  serial element.
- in_valid  input  1  in_data valid.
- in_last  input  1  marks the final element of a frame; qualified by in_valid.
- in_ready  output  1  collector can accept in_data this cycle.
- frame_data  output  [N-1:0][DATA_W-1:0]  assembled frame; index = row*INPUT_SIZE+col.
- frame_valid  output  1  frame_data holds a complete frame.
- frame_ready  input  1  consumer takes the frame.
- frame_err  output  1  one-cycle pulse on an in_last framing error.
- err_count  output  8  saturating count of framing errors.

Behaviour:
- Storage: two banks of N x DATA_W registers, each with a state of EMPTY, FILLING or FULL.
  - wr_bank and rd_bank pointers are 1 bit each.
  - wr_idx counts 0..N-1 with width clog2(N), minimum 1.
- Reset (rst_n=0 at a clock edge):
  - Both banks go EMPTY; wr_bank=rd_bank=0; wr_idx=0.
  - in_ready=0 during reset. frame_valid=0, frame_err=0, err_count=0.
  - frame_data contents are don't-care but must not be X-propagating; clear them to 0.
  - Reset mid-frame discards all partial and full frames.
- in_ready = (bank[wr_bank] != FULL), registered-free (combinational from state).
- Accept: when in_valid && in_ready, bank[wr_bank][wr_idx] <= in_data. Bank becomes FILLING if it was EMPTY.
- Completion: wr_idx==N-1 && in_last on an accepted element.
  - Bank becomes FULL and wr_idx resets to 0.
  - wr_bank toggles.
- Framing errors (on an accepted element):
  - in_last at wr_idx<N-1, or wr_idx==N-1 without in_last.
  - The element is discarded; wr_idx <= 0; the bank stays FILLING/EMPTY and is refilled from index 0.
  - frame_err pulses high the next cycle; err_count increments, saturating at 255.
- frame_valid = (bank[rd_bank]==FULL); frame_data = bank[rd_bank] (combinational mux).
  - Latency: the last element accepted at edge k gives frame_valid=1 after edge k, i.e. usable in cycle k+1.
- Consume: frame_valid && frame_ready -> bank[rd_bank] <= EMPTY; rd_bank toggles.
  - frame_data must stay stable while frame_valid=1 and frame_ready=0.
- Simultaneous events:
  - Consuming one bank and completing the other in the same cycle is legal. Both updates take effect, and frame_valid stays 1 the next cycle, showing the new frame.
  - Consuming bank X while writing bank X's first element is impossible: wr_bank only points at a FULL bank when in_ready=0.
- Backpressure: with both banks FULL, in_ready=0 until a consume. in_ready rises in the cycle after the consume edge.
- Throughput: sustains one element per cycle indefinitely if frame_ready is held high.
- Ordering: frames are emitted in arrival order; no frame is dropped or duplicated.

Decomposition:
- Shared package cnn_pkg holds:
  - DATA_W=32.
  - typedef logic [31:0] elem_t.
  - typedef enum {BANK_EMPTY, BANK_FILLING, BANK_FULL} bank_state_t.
  - A clog2-based index-width helper.
- One natural sub-module: fm_bank, one frame register bank. It has a write-enable/index/data port, a clear input and a parallel frame output, and is instantiated twice.
- Top level holds the pointers, bank states, error logic and output mux.

Test Plan:
- INPUT_SIZE=4, stream values 1..16 with in_last on 16, frame_ready=1 -> frame_valid high for exactly 1 cycle the cycle after element 16; frame_data[0]=1, frame_data[15]=16; no frame_err.
- Stream three back-to-back frames (1..16, 17..32, 33..48) with frame_ready=0:
  - in_ready drops after element 32; frame_data holds 1..16 stable.
  - Raise frame_ready for 1 cycle -> frame_data shows 17..32, and in_ready returns the next cycle.
  - Frame 3 completes, then is emitted after the next consume.
- in_last asserted on element 10 -> frame_err pulses once, err_count=1. Next 16 elements (100..115 with in_last on 115) emit frame_data[0]=100, frame_data[15]=115.
- Element 16 sent without in_last -> frame_err pulse, no frame_valid; 300 consecutive errors -> err_count saturates at 255.
- Same-cycle event: frame_ready=1 on frame A while the last element of frame B is accepted -> frame A consumed, frame_valid remains 1 next cycle with frame B.
- rst_n=0 for one cycle after element 7 of a frame, with the other bank FULL -> frame_valid=0, in_ready=1 post-reset. A fresh 16-element frame is emitted correctly with no stale data.
